// File: rtl/func_arbiter_pkg.sv
// func_arbiter_pkg: shared return-path widths, FIFO word field split and mailbox FSM states.
package func_arbiter_pkg;
  localparam int RET_DW = 16;
  localparam int VAL_LSB = 0;
  localparam int CHILD_LSB = RET_DW;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} mbox_state_e;
endpackage

// File: rtl/ret_mailbox.sv
// ret_mailbox: per-parent mailbox parking child return values by child ID and serving blocking waits.
// Optional RET_MAILBOX_BYPASS_EN delivers a matching FIFO head straight to the waiter.
module ret_mailbox
  import func_arbiter_pkg::*;
#(
  parameter int CHILD = 4,
  parameter int LOG_CHILD = (CHILD == 1) ? 1 : $clog2(CHILD),
  parameter int FULL_RET_DW = RET_DW + LOG_CHILD
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   retFifo_empty_n_i,
  input  logic [FULL_RET_DW-1:0] retFifo_dout_i,
  output logic                   retFifo_pop_o,
  input  logic                   wait_req_i,
  input  logic [LOG_CHILD-1:0]   wait_child_i,
  output logic                   wait_ack_o,
  output logic [RET_DW-1:0]      wait_data_o,
  output logic [CHILD-1:0]       slot_vld_o,
  output logic [LOG_CHILD:0]     pend_cnt_o
);
  mbox_state_e state;
  logic [RET_DW-1:0] slot [CHILD];
  logic [CHILD-1:0] slot_vld;
  logic [LOG_CHILD:0] pend;
  logic [LOG_CHILD-1:0] head_child;
  logic [RET_DW-1:0] head_val;
  logic legal, active, hit, serve, bypass, take, write;
  logic [CHILD-1:0] set_mask, clr_mask;
  assign head_child = retFifo_dout_i[FULL_RET_DW-1:CHILD_LSB];
  assign head_val = retFifo_dout_i[CHILD_LSB-1:VAL_LSB];
  assign legal = 32'(head_child) < CHILD;
  assign active = (state == IDLE && wait_req_i) || state == WAIT;
  assign hit = slot_vld[wait_child_i];
  assign serve = active && hit;
`ifdef RET_MAILBOX_BYPASS_EN
  assign bypass = active && !hit && retFifo_empty_n_i && head_child == wait_child_i;
`else
  assign bypass = 1'b0;
`endif
  assign take = serve || bypass;
  // illegal child IDs are popped and dropped so the FIFO never wedges
  assign retFifo_pop_o = retFifo_empty_n_i && (!legal || !slot_vld[head_child]);
  assign write = retFifo_pop_o && legal && !bypass;
  assign set_mask = write ? CHILD'(1) << head_child : '0;
  assign clr_mask = serve ? CHILD'(1) << wait_child_i : '0;
  assign slot_vld_o = slot_vld;
  assign pend_cnt_o = pend;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      wait_ack_o <= 1'b0;
      wait_data_o <= '0;
    end else begin
      wait_ack_o <= take;
      if (take) wait_data_o <= serve ? slot[wait_child_i] : head_val;
      state <= state == ACK ? IDLE : take ? ACK : active ? WAIT : IDLE;
    end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      slot_vld <= '0;
      pend <= '0;
      for (int i = 0; i < CHILD; i++) slot[i] <= '0;
    end else begin
      if (write) slot[head_child] <= head_val;
      slot_vld <= (slot_vld | set_mask) & ~clr_mask;
      pend <= pend + (LOG_CHILD+1)'(write) - (LOG_CHILD+1)'(serve);
    end
  assert property (@(posedge clk) disable iff (!rstn) retFifo_empty_n_i |-> legal);
endmodule

// File: tb/tb_ret_mailbox.sv
// tb_ret_mailbox: directed stimulus with a per-cycle comparison against a slot-map model of the mailbox.
module tb_ret_mailbox;
  import func_arbiter_pkg::*;
  localparam int CHILD = 4;
  localparam int LC = 2;
  localparam int FW = RET_DW + LC;
  logic clk = 0, rstn = 0, empty_n = 0, req = 0;
  logic [FW-1:0] dout = '0;
  logic [LC-1:0] wc = '0;
  logic pop, ack;
  logic [RET_DW-1:0] data;
  logic [CHILD-1:0] vld;
  logic [LC:0] cnt;
  int tests = 0, fails = 0;
  ret_mailbox #(.CHILD(CHILD)) dut (
    .clk(clk), .rstn(rstn),
    .retFifo_empty_n_i(empty_n), .retFifo_dout_i(dout), .retFifo_pop_o(pop),
    .wait_req_i(req), .wait_child_i(wc), .wait_ack_o(ack), .wait_data_o(data),
    .slot_vld_o(vld), .pend_cnt_o(cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: which children have a parked value, and whether a waiter is pending or being acked
  bit m_vld [CHILD] = '{default: 0};
  logic [RET_DW-1:0] m_val [CHILD];
  bit m_wait = 0, m_ack = 0;
  logic [RET_DW-1:0] m_data = '0;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      foreach (m_vld[i]) m_vld[i] = 0;
      m_wait = 0;
      m_ack = 0;
      m_data = '0;
    end else begin
      automatic int hc = int'(dout[FW-1:RET_DW]);
      automatic int c = int'(wc);
      automatic bit listen = !m_ack && (m_wait || req);
      automatic bit srv = listen && m_vld[c];
      automatic bit p = empty_n && !m_vld[hc];
      automatic bit byp = 0;
`ifdef RET_MAILBOX_BYPASS_EN
      byp = listen && !m_vld[c] && empty_n && hc == c;
`endif
      if (srv) begin
        m_data = m_val[c];
        m_vld[c] = 0;
      end
      if (byp) m_data = dout[RET_DW-1:0];
      else if (p) begin
        m_vld[hc] = 1;
        m_val[hc] = dout[RET_DW-1:0];
      end
      m_ack = srv || byp;
      m_wait = listen && !m_ack;
    end
  end
  always @(negedge clk) begin
    automatic int hc = int'(dout[FW-1:RET_DW]);
    automatic int n = 0;
    automatic logic [CHILD-1:0] mv;
    foreach (m_vld[i]) begin
      n += int'(m_vld[i]);
      mv[i] = m_vld[i];
    end
    chk("cyc_pop", pop, empty_n && !m_vld[hc]);
    chk("cyc_ack", ack, m_ack);
    chk("cyc_data", data, m_data);
    chk("cyc_slot_vld", vld, mv);
    chk("cyc_pend", cnt, n);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [LC-1:0] c, input logic [RET_DW-1:0] v);
    empty_n = 1;
    dout = {c, v};
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (pop) begin
        tick();
        empty_n = 0;
        return;
      end
    end
    chk("push_timeout", 0, 1);
    empty_n = 0;
  endtask
  task automatic do_wait(input logic [LC-1:0] c, input logic [RET_DW-1:0] exp, input int lat);
    req = 1;
    wc = c;
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (ack) begin
        chk("wait_data", data, exp);
        if (lat > 0) chk("wait_lat", n, lat);
        req = 0;
        tick();
        return;
      end
    end
    chk("wait_timeout", 0, 1);
    req = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) tick();
    chk("rst_vld", vld, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_pop", pop, 0);
    chk("rst_data", data, 0);
    rstn = 1;
    tick();
    // pre-parked value
    push(2, 16'h1234);
    chk("park_vld", vld, 4'b0100);
    chk("park_cnt", cnt, 1);
    repeat (3) tick();
    do_wait(2, 16'h1234, 1);
    chk("park_vld_clr", vld, 0);
    chk("park_cnt_clr", cnt, 0);
    // wait before the value arrives
    fork
      do_wait(1, 16'h00AA, -1);
      begin
        repeat (5) tick();
        push(1, 16'h00AA);
`ifdef RET_MAILBOX_BYPASS_EN
        chk("wf_ack_byp", ack, 1);
`else
        chk("wf_ack_early", ack, 0);
        tick();
        chk("wf_ack", ack, 1);
`endif
      end
    join
    tick();
    // out-of-order arrivals
    push(3, 16'h0030);
    push(0, 16'h0000);
    push(2, 16'h0020);
    chk("ooo_vld", vld, 4'b1101);
    chk("ooo_cnt", cnt, 3);
    do_wait(0, 16'h0000, 1);
    do_wait(2, 16'h0020, 1);
    do_wait(3, 16'h0030, 1);
    chk("ooo_cnt_end", cnt, 0);
    // head-of-line stall
    push(0, 16'h0101);
    empty_n = 1;
    dout = {2'd0, 16'h0202};
    repeat (3) begin
      @(negedge clk);
      chk("hol_stall", pop, 0);
    end
    tick();
    req = 1;
    wc = 0;
    tick();
    chk("hol_ack", ack, 1);
    chk("hol_data", data, 16'h0101);
    req = 0;
    @(negedge clk);
    chk("hol_pop", pop, 1);
    tick();
    empty_n = 0;
    chk("hol_vld", vld, 4'b0001);
    do_wait(0, 16'h0202, 1);
    // concurrent pop and serve
    push(1, 16'h0011);
    chk("cc_cnt_pre", cnt, 1);
    req = 1;
    wc = 1;
    empty_n = 1;
    dout = {2'd2, 16'h0055};
    @(negedge clk);
    chk("cc_pop", pop, 1);
    tick();
    empty_n = 0;
    req = 0;
    chk("cc_ack", ack, 1);
    chk("cc_data", data, 16'h0011);
    chk("cc_vld", vld, 4'b0100);
    chk("cc_cnt", cnt, 1);
    tick();
    do_wait(2, 16'h0055, 1);
    // reset while waiting
    push(1, 16'h0077);
    req = 1;
    wc = 3;
    repeat (3) tick();
    rstn = 0;
    #1;
    chk("rw_ack", ack, 0);
    chk("rw_vld", vld, 0);
    chk("rw_cnt", cnt, 0);
    req = 0;
    repeat (2) tick();
    chk("rw_ack_hold", ack, 0);
    rstn = 1;
    tick();
    push(3, 16'h0333);
    do_wait(3, 16'h0333, 1);
    chk("rw_cnt_end", cnt, 0);
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
